// File: rtl/mdr_mem_port_if.sv
// mdr_mem_port_if: memory-side request/acknowledge handshake of the memory data register
interface mdr_mem_port_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_rdata, mem_ack);
  modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, output mem_rdata, mem_ack);
endinterface

// File: rtl/mdr_mem_port.sv
// mdr_mem_port: memory data register with A/B bus reads and a sequenced memory load/store; MDR_TIMEOUT_EN adds an ack timeout with sticky err
module mdr_mem_port #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write_c,
  input  logic [DATA_W-1:0] c_bus,
  input  logic              read_a,
  input  logic              read_b,
  output logic [DATA_W-1:0] a_bus,
  output logic [DATA_W-1:0] b_bus,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] addr,
  mdr_mem_port_if.master    mem,
  output logic              busy,
  output logic              done,
  output logic              err
);
  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, DONE} state_t;
  state_t state, state_n;
  logic [DATA_W-1:0] data;
  logic waiting, tmo;
  assign waiting = state == RD_WAIT || state == WR_WAIT;
  assign busy = state != IDLE;
`ifdef MDR_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt;
  assign tmo = waiting && !mem.mem_ack && cnt == CNT_W'(TIMEOUT_CYC - 1);
  // Entry to a wait state is always from IDLE, so clearing in IDLE covers it
  always_ff @(posedge clk) begin
    if (rst || state == IDLE) cnt <= '0;
    else if (waiting) cnt <= cnt + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) err <= 1'b0;
    else if (tmo) err <= 1'b1;
  end
`else
  assign tmo = 1'b0;
  assign err = TIMEOUT_CYC < 0;
`endif
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (mem_read ? RD_WAIT : mem_write ? WR_WAIT : IDLE) :
              state == DONE ? IDLE :
              (mem.mem_ack || tmo) ? DONE : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      data          <= '0;
      a_bus         <= '0;
      b_bus         <= '0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      done          <= 1'b0;
    end else begin
      done <= state == DONE;
      if (read_a) a_bus <= data;
      if (read_b) b_bus <= data;
      if (state == IDLE) begin
        if (mem_read) begin
          mem.mem_addr <= addr;
          mem.mem_req  <= 1'b1;
          mem.mem_we   <= 1'b0;
        end else if (mem_write) begin
          mem.mem_addr  <= addr;
          mem.mem_wdata <= data;
          mem.mem_req   <= 1'b1;
          mem.mem_we    <= 1'b1;
        end else if (write_c) begin
          data <= c_bus;
        end
      end else if (waiting && (mem.mem_ack || tmo)) begin
        mem.mem_req <= 1'b0;
        if (state == RD_WAIT && mem.mem_ack) data <= mem.mem_rdata;
      end
    end
  end
endmodule

// File: tb/tb_mdr_mem_port.sv
// tb_mdr_mem_port: scoreboard bench for mdr_mem_port (bus reads and memory transactions)
module tb_mdr_mem_port;
  localparam int DW = 16;
  localparam int AW = 16;
  logic clk = 0, rst = 1, write_c = 0, read_a = 0, read_b = 0, mem_read = 0, mem_write = 0;
  logic [DW-1:0] c_bus = '0, a_bus, b_bus;
  logic [AW-1:0] addr = '0;
  logic busy, done, err;
  int n_cmp = 0, n_bad = 0;
  logic [DW-1:0] model = '0;
  logic [DW-1:0] qa[$], qb[$];
  typedef struct {logic we; logic [AW-1:0] a; logic [DW-1:0] wd;} tx_t;
  tx_t tq[$];

  mdr_mem_port_if #(.DATA_W(DW), .ADDR_W(AW)) mem();
  mdr_mem_port #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst(rst), .write_c(write_c), .c_bus(c_bus), .read_a(read_a), .read_b(read_b),
    .a_bus(a_bus), .b_bus(b_bus), .mem_read(mem_read), .mem_write(mem_write), .addr(addr),
    .mem(mem), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin : mon
    logic sa, sb;
    sa = read_a && !rst;
    sb = read_b && !rst;
    #1;
    if (sa) begin
      check("a_queue", qa.size(), 1);
      if (qa.size() != 0) check("a_bus", a_bus, qa.pop_front());
    end
    if (sb) begin
      check("b_queue", qb.size(), 1);
      if (qb.size() != 0) check("b_bus", b_bus, qb.pop_front());
    end
  end

  task automatic wr_c(input logic [DW-1:0] v, input logic ra, input logic rb);
    write_c = 1; c_bus = v; read_a = ra; read_b = rb;
    if (ra) qa.push_back(model);
    if (rb) qb.push_back(model);
    model = v;
    @(negedge clk);
    write_c = 0; read_a = 0; read_b = 0;
  endtask

  task automatic rd_bus(input logic ra, input logic rb);
    read_a = ra; read_b = rb;
    if (ra) qa.push_back(model);
    if (rb) qb.push_back(model);
    @(negedge clk);
    read_a = 0; read_b = 0;
  endtask

  // dly = cycle whose closing edge samples mem_ack; 0 means never acknowledge
  task automatic txn(input logic we, input logic collide, input logic [AW-1:0] a, input logic [DW-1:0] rd,
                     input int dly, input int exp_req, input int exp_lat, input string tag);
    int req, dn, lat, lim;
    tx_t x;
    if (collide) begin
      mem_read = 1; mem_write = 1; write_c = 1; c_bus = 16'hBEEF;
    end else if (we) mem_write = 1;
    else mem_read = 1;
    addr = a;
    tq.push_back('{we && !collide, a, model});
    lim = (dly != 0 ? dly : 9) + 4;
    req = 0; dn = 0; lat = -1;
    for (int t = 1; t <= lim; t++) begin
      @(negedge clk);
      mem_read = 0; mem_write = 0;
      write_c = collide && t < dly;
      mem.mem_ack = t == dly;
      mem.mem_rdata = t == dly ? rd : DW'($urandom);
      req += int'(mem.mem_req);
      if (t == 1) check({tag, "_busy"}, busy, 1);
      if (mem.mem_ack && mem.mem_req && tq.size() != 0) begin
        x = tq.pop_front();
        check({tag, "_we"}, mem.mem_we, x.we);
        check({tag, "_addr"}, mem.mem_addr, x.a);
        if (x.we) check({tag, "_wdata"}, mem.mem_wdata, x.wd);
      end
      if (done) begin
        dn++;
        if (lat < 0) lat = t - 1;
      end
    end
    mem.mem_ack = 0;
    check({tag, "_req_cycles"}, req, exp_req);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_done_pulses"}, dn, 1);
    check({tag, "_idle"}, busy, 0);
    if ((!we || collide) && dly != 0) model = rd;
  endtask

  initial begin
    int dn;
    mem.mem_ack = 0;
    mem.mem_rdata = '0;
    repeat (3) @(negedge clk);
    check("rst_a", a_bus, 0);
    check("rst_b", b_bus, 0);
    check("rst_req", mem.mem_req, 0);
    check("rst_we", mem.mem_we, 0);
    check("rst_addr", mem.mem_addr, 0);
    check("rst_wdata", mem.mem_wdata, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    rst = 0;
    @(negedge clk);
    wr_c(16'hA5A5, 0, 0);
    rd_bus(1, 1);
    txn(0, 0, 16'h0040, 16'h1234, 4, 4, 5, "rd");
    rd_bus(1, 0);
    wr_c(16'h00FF, 0, 0);
    txn(1, 0, 16'h0010, 16'h0000, 1, 1, 2, "wr");
    rd_bus(0, 1);
    txn(0, 1, 16'h0300, 16'h5A5A, 3, 3, 4, "col");
    rd_bus(1, 1);
    wr_c(16'h1357, 1, 0);
    rd_bus(1, 0);
    // reset in the middle of a read
    mem_read = 1; addr = 16'h0080;
    @(negedge clk);
    mem_read = 0;
    check("abort_req_before", mem.mem_req, 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    model = '0;
    check("abort_req", mem.mem_req, 0);
    check("abort_busy", busy, 0);
    check("abort_a", a_bus, 0);
    dn = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) dn++;
    end
    check("abort_no_done", dn, 0);
    rd_bus(0, 1);
`ifdef MDR_TIMEOUT_EN
    wr_c(16'h4242, 0, 0);
    txn(0, 0, 16'h0200, 16'hDEAD, 0, 8, 9, "tmo");
    tq.delete();
    check("tmo_err", err, 1);
    rd_bus(1, 0);
    repeat (3) @(negedge clk);
    check("tmo_err_sticky", err, 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    model = '0;
    check("tmo_err_cleared", err, 0);
`else
    check("err_tied", err, 0);
`endif
    @(negedge clk);
    check("a_queue_drained", qa.size(), 0);
    check("b_queue_drained", qb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
